// File: rtl/psum_acc_drain.sv
// Pops acc_len signed partial sums from a registered-read FIFO, accumulates them with
// saturation, optionally clamps negatives to zero, and presents the result on a valid/ready port.
module psum_acc_drain #(
  parameter  int bw_psum = 12,
  parameter  int bw_acc  = 16,
  parameter  int pr      = 8,
  localparam int cnt_w   = $clog2(pr) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [cnt_w-1:0]   acc_len,
  input  logic               relu_en,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [bw_psum-1:0] fifo_rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [bw_acc-1:0]  out_data,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  localparam logic signed [bw_acc-1:0] SAT_MAX = {1'b0, {(bw_acc-1){1'b1}}};
  localparam logic signed [bw_acc-1:0] SAT_MIN = {1'b1, {(bw_acc-1){1'b0}}};

  state_t                    r_state;
  logic signed [bw_acc-1:0]  r_sum;
  logic        [cnt_w-1:0]   r_len;
  logic        [cnt_w-1:0]   r_iss;
  logic        [cnt_w-1:0]   r_rcv;
  logic                      r_relu;
  logic                      r_dv;

  logic signed [bw_acc:0]    w_rd_ext;
  logic signed [bw_acc:0]    w_sum_ext;
  logic signed [bw_acc:0]    w_add;
  logic signed [bw_acc-1:0]  w_sat;

  // One guard bit above the accumulator; a disagreement between the top two bits is overflow.
  assign w_rd_ext  = {{(bw_acc+1-bw_psum){fifo_rd_data[bw_psum-1]}}, fifo_rd_data};
  assign w_sum_ext = {r_sum[bw_acc-1], r_sum};
  assign w_add     = w_rd_ext + w_sum_ext;
  assign w_sat     = (w_add[bw_acc] != w_add[bw_acc-1]) ? (w_add[bw_acc] ? SAT_MIN : SAT_MAX)
                                                        : w_add[bw_acc-1:0];

  // Outputs are decodes of registered state, forced low while reset is held.
  assign fifo_rd_en = !reset && (r_state == S_ACC) && (r_iss < r_len) && !fifo_empty;
  assign out_valid  = !reset && (r_state == S_OUT);
  assign out_data   = (!out_valid || (r_relu && r_sum[bw_acc-1])) ? '0 : r_sum;
  assign busy       = !reset && (r_state != S_IDLE);
  assign done       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sum   <= '0;
      r_len   <= '0;
      r_iss   <= '0;
      r_rcv   <= '0;
      r_relu  <= 1'b0;
      r_dv    <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len   <= acc_len;
            r_relu  <= relu_en;
            r_sum   <= '0;
            r_iss   <= '0;
            r_rcv   <= '0;
            r_state <= (acc_len == '0) ? S_OUT : S_ACC;
          end
        end
        S_ACC: begin
          if (fifo_rd_en) r_iss <= r_iss + 1'b1;
          r_dv <= fifo_rd_en;
          // Read data lands one cycle after the pop; the last word moves straight to OUT.
          if (r_dv) begin
            r_sum <= w_sat;
            r_rcv <= r_rcv + 1'b1;
            if (r_rcv == r_len - 1'b1) r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_acc_drain.sv
// Bench for psum_acc_drain: a 16-bit and a saturating 12-bit instance share one FIFO model;
// expected results are queued at start and checked on each output handshake.
module tb_psum_acc_drain;
  localparam int PW  = 12;
  localparam int AW  = 16;
  localparam int AWS = 12;
  localparam int PR  = 8;
  localparam int CW  = $clog2(PR) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, start, relu_en, out_ready;
  logic [CW-1:0]   acc_len;
  logic [PW-1:0]   fifo_rd_data = '0;
  logic            fifo_empty;
  logic            fifo_rd_en, out_valid, busy, done;
  logic [AW-1:0]   out_data;
  logic            rd_en_s, out_valid_s, busy_s, done_s;
  logic [AWS-1:0]  out_data_s;

  psum_acc_drain #(.bw_psum(PW), .bw_acc(AW), .pr(PR)) dut (
    .clk(clk), .reset(reset), .start(start), .acc_len(acc_len), .relu_en(relu_en),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done));

  psum_acc_drain #(.bw_psum(PW), .bw_acc(AWS), .pr(PR)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .acc_len(acc_len), .relu_en(relu_en),
    .fifo_empty(fifo_empty), .fifo_rd_en(rd_en_s), .fifo_rd_data(fifo_rd_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .busy(busy_s),
    .done(done_s));

  // FIFO model with registered read data; both instances pop in lockstep.
  logic [PW-1:0] mem [0:127];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk)
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end

  typedef struct { int e16; int e12; } exp_t;
  exp_t exp_q[$];
  exp_t m_e;
  int checks = 0, errors = 0, pops = 0, dones = 0, viol = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fifo_rd_en && !fifo_empty) pops++;
    if (done) dones++;
    if (fifo_rd_en && (fifo_empty || !busy)) viol++;
    if (rd_en_s !== fifo_rd_en || out_valid_s !== out_valid || busy_s !== busy || done_s !== done)
      viol++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result got %0d expected none", $signed(out_data));
      end else begin
        m_e = exp_q.pop_front();
        chk("data16", $signed(out_data), m_e.e16);
        chk("data12", $signed(out_data_s), m_e.e12);
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push(input int w);
    mem[wr_ptr] = PW'(w);
    wr_ptr++;
  endtask

  task automatic do_start(input int len, input bit relu, input int e16, input int e12);
    int lat;
    exp_t e;
    e.e16 = e16; e.e12 = e12;
    exp_q.push_back(e);
    pops = 0; dones = 0;
    acc_len = CW'(len); relu_en = relu; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin tick; lat++; end
    tick; tick;
    chk("latency", lat, (len == 0) ? 1 : len + 2);
    chk("pops", pops, len);
    chk("done_pulses", dones, 1);
    chk("idle_after", busy, 0);
  endtask

  typedef struct { int len; bit relu; int w[8]; int e16; int e12; } vec_t;
  vec_t vt[8];

  initial begin
    int k, d0;
    bit stable;
    vt[0] = '{4, 1'b0, '{3, 5, -2, 7, 0, 0, 0, 0}, 13, 13};
    vt[1] = '{2, 1'b1, '{-100, 20, 0, 0, 0, 0, 0, 0}, 0, 0};
    vt[2] = '{2, 1'b0, '{-100, 20, 0, 0, 0, 0, 0, 0}, -80, -80};
    vt[3] = '{8, 1'b0, '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047}, 16376, 2047};
    vt[4] = '{8, 1'b0, '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048}, -16384, -2048};
    vt[5] = '{0, 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 0};
    vt[6] = '{3, 1'b0, '{1500, 1500, -1000, 0, 0, 0, 0, 0}, 2000, 1047};
    vt[7] = '{3, 1'b0, '{-1500, -1500, 1000, 0, 0, 0, 0, 0}, -2000, -1048};

    reset = 1'b1; start = 1'b0; relu_en = 1'b0; out_ready = 1'b1; acc_len = '0;
    tick; tick;
    @(negedge clk);
    chk("reset_outputs", {fifo_rd_en, out_valid, busy, done, out_data}, 0);
    tick;
    reset = 1'b0;
    tick;

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < vt[v].len; i++) push(vt[v].w[i]);
      tick;
      do_start(vt[v].len, vt[v].relu, vt[v].e16, vt[v].e12);
    end

    // Empty FIFO stalls the run; result held under backpressure; start in handshake cycle ignored.
    out_ready = 1'b0;
    exp_q.push_back('{2, 2});
    pops = 0; dones = 0;
    acc_len = CW'(2); relu_en = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    chk("stall_no_pop", pops, 0);
    chk("stall_busy", busy, 1);
    push(1); push(1);
    k = 0;
    while (!out_valid && k < 40) begin tick; k++; end
    chk("stall_valid", out_valid, 1);
    d0 = int'($signed(out_data));
    stable = 1'b1;
    repeat (4) begin
      tick;
      if (!out_valid || int'($signed(out_data)) != d0 || done) stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    chk("hold_no_done", dones, 0);
    out_ready = 1'b1; start = 1'b1; acc_len = CW'(3);
    tick;
    start = 1'b0;
    chk("start_in_handshake_ignored", busy, 0);
    chk("stall_done_pulses", dones, 1);
    chk("stall_pops", pops, 2);
    tick;

    // A start pulsed during ACC must not restart the run.
    push(3); push(5); push(-2); push(7);
    tick;
    exp_q.push_back('{13, 13});
    pops = 0; dones = 0;
    acc_len = CW'(4); relu_en = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    start = 1'b1; acc_len = CW'(1); relu_en = 1'b1;
    tick;
    start = 1'b0; relu_en = 1'b0;
    k = 3;
    while (!out_valid && k < 60) begin tick; k++; end
    tick; tick;
    chk("acc_start_latency", k, 6);
    chk("acc_start_pops", pops, 4);
    chk("acc_start_done", dones, 1);

    // Reset after two of four pops; the remaining words feed a fresh run.
    push(5); push(6); push(9); push(1);
    tick;
    pops = 0;
    acc_len = CW'(4); start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs", {fifo_rd_en, out_valid, busy, done, out_data}, 0);
    chk("mid_reset_pops", pops, 2);
    tick;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {busy, out_valid}, 0);
    tick;
    do_start(2, 1'b0, 10, 10);

    repeat (3) tick;
    chk("results_outstanding", exp_q.size(), 0);
    chk("protocol_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
